// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes,
// datapath mux/ALU codes and the bundled control word.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10
  } state_t;

  // Supported instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath strobe the controller drives, bundled as one word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // True for the five opcodes the datapath can execute
  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Pure combinational decode of the current FSM state into the datapath
// control word. Only FETCH looks at mem_ready, only DECODE looks at opcode.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Every strobe defaults low; each state raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.illegal   = ~op_legal(opcode);
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor controller: state register, next-state sequencing
// with memory wait states, and a wrapping retired-instruction counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q;
  state_t           state_d;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] count_q;

  // State register; reset drops straight to IDLE so no strobe outlives it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; FETCH/MEMRD/MEMWR hold until memory completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_RWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_RWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // An instruction retires whenever the machine returns to FETCH from any
  // state other than IDLE or a FETCH stall (DECODE only does so when illegal)
  always_comb begin
    retire = (state_d == ST_FETCH) &&
             (state_q != ST_IDLE) && (state_q != ST_FETCH);
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 1'b1;
    end
  end

  mc_out_decode u_out_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = ctrl.illegal;
  assign state         = state_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instructions with random
// memory stalls; expected state traces and per-instruction strobe tallies
// are queued by the stimulus side and consumed by an independent monitor.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  // Spec state numbers and opcodes, kept independent of the design package
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
  localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_BRANCH = 9, S_JUMP = 10;
  localparam logic [5:0] O_R = 6'h00, O_LW = 6'h23, O_SW = 6'h2B, O_BEQ = 6'h04, O_J = 6'h02;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = 6'h00;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  // Per-instruction tally of cycles in which each strobe/code was active
  typedef struct {
    int cycles;
    int mem_read;
    int iord;
    int mem_write;
    int ir_write;
    int pc_write;
    int pc_write_cond;
    int reg_write;
    int reg_dst;
    int mem_to_reg;
    int alu_src_a;
    int srcb_four;
    int srcb_imm;
    int srcb_sh2;
    int aluop_sub;
    int aluop_funct;
    int pcsrc_out;
    int pcsrc_jump;
    int illegal;
    int count;
  } rec_t;

  rec_t exp_rec_q[$];
  int   exp_state_q[$];
  int   total = 0;
  int   bad = 0;
  int   retired = 0;
  bit   mon_en = 1'b0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .illegal       (illegal),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive_cycle(input logic mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Reference model: from the opcode class and stall counts, queue the
  // state trace and strobe tally, then drive mem_ready cycle by cycle
  task automatic applyStimulus(input int kind, input logic [5:0] op, input int sf, input int sm);
    rec_t r;
    r = '{default: 0};
    r.mem_read  = sf + 1;
    r.srcb_four = sf + 1;
    r.ir_write  = 1;
    r.pc_write  = 1;
    r.srcb_sh2  = 1;
    for (int i = 0; i <= sf; i++) exp_state_q.push_back(S_FETCH);
    exp_state_q.push_back(S_DECODE);
    case (kind)
      0: begin
        exp_state_q.push_back(S_EXEC);
        exp_state_q.push_back(S_RWB);
        r.cycles = sf + 4; r.alu_src_a = 1; r.aluop_funct = 1;
        r.reg_dst = 1; r.reg_write = 1;
      end
      1: begin
        exp_state_q.push_back(S_MEMADR);
        for (int i = 0; i <= sm; i++) exp_state_q.push_back(S_MEMRD);
        exp_state_q.push_back(S_MEMWB);
        r.cycles = sf + sm + 5; r.alu_src_a = 1; r.srcb_imm = 1;
        r.mem_read += sm + 1; r.iord = sm + 1; r.mem_to_reg = 1; r.reg_write = 1;
      end
      2: begin
        exp_state_q.push_back(S_MEMADR);
        for (int i = 0; i <= sm; i++) exp_state_q.push_back(S_MEMWR);
        r.cycles = sf + sm + 4; r.alu_src_a = 1; r.srcb_imm = 1;
        r.mem_write = sm + 1; r.iord = sm + 1;
      end
      3: begin
        exp_state_q.push_back(S_BRANCH);
        r.cycles = sf + 3; r.alu_src_a = 1; r.aluop_sub = 1;
        r.pc_write_cond = 1; r.pcsrc_out = 1;
      end
      4: begin
        exp_state_q.push_back(S_JUMP);
        r.cycles = sf + 3; r.pc_write += 1; r.pcsrc_jump = 1;
      end
      default: begin
        r.cycles = sf + 2; r.illegal = 1;
      end
    endcase
    retired++;
    r.count = retired % (1 << CNT_W);
    exp_rec_q.push_back(r);

    opcode = op;
    repeat (sf) drive_cycle(1'b0);
    drive_cycle(1'b1);
    drive_cycle(rnd_bit());
    case (kind)
      0: begin drive_cycle(rnd_bit()); drive_cycle(rnd_bit()); end
      1: begin
        drive_cycle(rnd_bit());
        repeat (sm) drive_cycle(1'b0);
        drive_cycle(1'b1);
        drive_cycle(rnd_bit());
      end
      2: begin
        drive_cycle(rnd_bit());
        repeat (sm) drive_cycle(1'b0);
        drive_cycle(1'b1);
      end
      3, 4: drive_cycle(rnd_bit());
      default: ;
    endcase
  endtask

  function automatic logic [5:0] pick_opcode(input int kind);
    logic [5:0] op;
    case (kind)
      0: op = O_R;
      1: op = O_LW;
      2: op = O_SW;
      3: op = O_BEQ;
      4: op = O_J;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op == O_R || op == O_LW || op == O_SW || op == O_BEQ || op == O_J)
          op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  task automatic finish_record(input rec_t a);
    rec_t e;
    if (exp_rec_q.size() == 0) begin
      checkOutput("rec_queue_underflow", 1, 0);
      return;
    end
    e = exp_rec_q.pop_front();
    checkOutput("cycles", a.cycles, e.cycles);
    checkOutput("mem_read", a.mem_read, e.mem_read);
    checkOutput("iord", a.iord, e.iord);
    checkOutput("mem_write", a.mem_write, e.mem_write);
    checkOutput("ir_write", a.ir_write, e.ir_write);
    checkOutput("pc_write", a.pc_write, e.pc_write);
    checkOutput("pc_write_cond", a.pc_write_cond, e.pc_write_cond);
    checkOutput("reg_write", a.reg_write, e.reg_write);
    checkOutput("reg_dst", a.reg_dst, e.reg_dst);
    checkOutput("mem_to_reg", a.mem_to_reg, e.mem_to_reg);
    checkOutput("alu_src_a", a.alu_src_a, e.alu_src_a);
    checkOutput("srcb_four", a.srcb_four, e.srcb_four);
    checkOutput("srcb_imm", a.srcb_imm, e.srcb_imm);
    checkOutput("srcb_sh2", a.srcb_sh2, e.srcb_sh2);
    checkOutput("aluop_sub", a.aluop_sub, e.aluop_sub);
    checkOutput("aluop_funct", a.aluop_funct, e.aluop_funct);
    checkOutput("pcsrc_out", a.pcsrc_out, e.pcsrc_out);
    checkOutput("pcsrc_jump", a.pcsrc_jump, e.pcsrc_jump);
    checkOutput("illegal", a.illegal, e.illegal);
    checkOutput("instr_count", int'(instr_count), e.count);
  endtask

  // Monitor: checks the state trace every cycle and closes out an
  // instruction's tally each time the machine re-enters FETCH
  initial begin
    rec_t acc;
    int   prev_state;
    bit   in_progress;
    acc = '{default: 0};
    prev_state = 0;
    in_progress = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && int'(state) != S_IDLE) begin
        if (exp_state_q.size() == 0) checkOutput("state_queue_underflow", 1, 0);
        else checkOutput("state", int'(state), exp_state_q.pop_front());
        if (int'(state) == S_FETCH && prev_state != S_FETCH) begin
          if (in_progress) finish_record(acc);
          acc = '{default: 0};
          in_progress = 1'b1;
        end
        acc.cycles++;
        acc.mem_read      += int'(mem_read);
        acc.iord          += int'(iord);
        acc.mem_write     += int'(mem_write);
        acc.ir_write      += int'(ir_write);
        acc.pc_write      += int'(pc_write);
        acc.pc_write_cond += int'(pc_write_cond);
        acc.reg_write     += int'(reg_write);
        acc.reg_dst       += int'(reg_dst);
        acc.mem_to_reg    += int'(mem_to_reg);
        acc.alu_src_a     += int'(alu_src_a);
        acc.srcb_four     += int'(alu_src_b == 2'b01);
        acc.srcb_imm      += int'(alu_src_b == 2'b10);
        acc.srcb_sh2      += int'(alu_src_b == 2'b11);
        acc.aluop_sub     += int'(alu_op == 2'b01);
        acc.aluop_funct   += int'(alu_op == 2'b10);
        acc.pcsrc_out     += int'(pc_source == 2'b01);
        acc.pcsrc_jump    += int'(pc_source == 2'b10);
        acc.illegal       += int'(illegal);
      end
      prev_state = int'(state);
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset check, directed opener, random run, reset-in-MEMWR
  initial begin
    int kind;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", int'(state), S_IDLE);
    checkOutput("reset_count", int'(instr_count), 0);
    checkOutput("reset_strobes",
                int'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal}), 0);

    reset = 1'b0;
    mon_en = 1'b1;
    drive_cycle(rnd_bit());

    applyStimulus(0, O_R, 0, 0);
    applyStimulus(1, O_LW, 0, 2);
    applyStimulus(2, O_SW, 1, 1);
    applyStimulus(3, O_BEQ, 0, 0);
    applyStimulus(4, O_J, 0, 0);
    applyStimulus(5, 6'h3F, 0, 0);
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      applyStimulus(kind, pick_opcode(kind), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    exp_state_q.push_back(S_FETCH);
    exp_state_q.push_back(S_FETCH);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    mon_en = 1'b0;
    checkOutput("state_queue_drained", exp_state_q.size(), 0);
    checkOutput("rec_queue_drained", exp_rec_q.size(), 0);

    opcode = O_SW;
    drive_cycle(1'b1);
    drive_cycle(rnd_bit());
    drive_cycle(rnd_bit());
    drive_cycle(1'b0);
    mem_ready = 1'b0;
    checkOutput("memwr_state", int'(state), S_MEMWR);
    checkOutput("memwr_write", int'(mem_write), 1);
    checkOutput("memwr_iord", int'(iord), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_write", int'(mem_write), 0);
    checkOutput("async_reset_state", int'(state), S_IDLE);
    checkOutput("async_reset_count", int'(instr_count), 0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_fetch", int'(state), S_FETCH);
    checkOutput("post_reset_write", int'(mem_write), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
